// File: rtl/four_to_one_rr_mux_pkg.sv
// rtl/four_to_one_rr_mux_pkg.sv - shared types and constants for the four-to-one merge
// Holds the channel-index encoding (same as the demux select), the state
// encoding of the one-entry output stage, and the default INACTIVE value.
package four_to_one_rr_mux_pkg;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH0 = 2'b00;
    localparam ch_idx_t CH1 = 2'b01;
    localparam ch_idx_t CH2 = 2'b10;
    localparam ch_idx_t CH3 = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int INACTIVE_DEF = 0;

endpackage

// File: rtl/four_to_one_rr_mux_if.sv
// rtl/four_to_one_rr_mux_if.sv - four valid/ready inputs merged onto one tagged output
// Ports:
//   in_valid[3:0]       per-channel request, bit i = channel i
//   in_data[4*DATA_W]   channel i payload in [i*DATA_W +: DATA_W]
//   in_ready[3:0]       one-hot or zero acceptance
//   out_valid/out_data/out_sel  registered output word and its source channel
//   out_ready           sink acceptance
// slave modport is the merge block, master modport is the producer/sink side.
interface four_to_one_rr_mux_if #(
    parameter int unsigned DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );
endinterface

// File: rtl/four_to_one_rr_mux_rr_arb4.sv
// rtl/four_to_one_rr_mux_rr_arb4.sv - combinational 4-way picker (round-robin or fixed priority)
// Ports:
//   req[3:0]        requests
//   last[1:0]       previously granted channel (round-robin start point)
//   gnt_onehot[3:0] one-hot grant, zero when no request
//   gnt_idx[1:0]    granted channel index (CH0 when no request)
//   any             at least one request present
// Macro FOUR_TO_ONE_FIXED_PRI_EN selects fixed priority (channel 0 highest);
// last is then ignored.
module rr_arb4
    import four_to_one_rr_mux_pkg::*;
(
    input  logic [3:0] req,
    input  ch_idx_t    last,
    output logic [3:0] gnt_onehot,
    output ch_idx_t    gnt_idx,
    output logic       any
);

    ch_idx_t idx;

`ifdef FOUR_TO_ONE_FIXED_PRI_EN
    logic unused_last;
    assign unused_last = ^last;

    // Scan lowest priority first so the highest-priority hit is written last.
    always_comb begin
        idx     = CH0;
        gnt_idx = CH0;
        for (int k = 3; k >= 0; k--) begin
            idx = ch_idx_t'(k);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end
`else
    // Candidates are last+1 .. last+4 (mod 4); scanning from +4 down to +1
    // leaves the nearest requester after last as the final winner.
    always_comb begin
        idx     = CH0;
        gnt_idx = CH0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + ch_idx_t'(k);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end
`endif

    assign any        = |req;
    assign gnt_onehot = any ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: rtl/four_to_one_rr_mux.sv
// rtl/four_to_one_rr_mux.sv - round-robin merge of four valid/ready channels into one registered output
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    four_to_one_rr_mux_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_sel/out_ready)
// Macro FOUR_TO_ONE_FIXED_PRI_EN: fixed priority (channel 0 highest), no last_grant register.
module four_to_one_rr_mux
    import four_to_one_rr_mux_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] INACTIVE = DATA_W'(INACTIVE_DEF)
) (
    input logic                  clk,
    input logic                  rst_n,
    four_to_one_rr_mux_if.slave  bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    ch_idx_t           sel_q, sel_d;
    ch_idx_t           arb_last;

    logic [3:0]        gnt_onehot;
    ch_idx_t           gnt_idx;
    logic              any;
    logic              open;
    logic              accept;
    logic [DATA_W-1:0] gnt_word;

`ifndef FOUR_TO_ONE_FIXED_PRI_EN
    ch_idx_t           last_q, last_d;
    assign arb_last = last_q;
`else
    assign arb_last = CH3;
`endif

    rr_arb4 u_arb (
        .req        (bus.in_valid),
        .last       (arb_last),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    always_comb begin
        gnt_word = bus.in_data[0 +: DATA_W];
        case (gnt_idx)
            CH1:     gnt_word = bus.in_data[DATA_W   +: DATA_W];
            CH2:     gnt_word = bus.in_data[2*DATA_W +: DATA_W];
            CH3:     gnt_word = bus.in_data[3*DATA_W +: DATA_W];
            default: gnt_word = bus.in_data[0 +: DATA_W];
        endcase
    end

    // The slot can take a new word when empty, or when the held word leaves
    // at this same edge; that overlap is what gives one word per cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifndef FOUR_TO_ONE_FIXED_PRI_EN
        last_d  = last_q;
`endif
        open    = (state_q == EMPTY) || (bus.out_ready && (state_q == FULL));
        accept  = open && any;

        if (accept) begin
            state_d = FULL;
            data_d  = gnt_word;
            sel_d   = gnt_idx;
`ifndef FOUR_TO_ONE_FIXED_PRI_EN
            last_d  = gnt_idx;
`endif
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
            data_d  = INACTIVE;
            sel_d   = CH0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= INACTIVE;
            sel_q   <= CH0;
`ifndef FOUR_TO_ONE_FIXED_PRI_EN
            last_q  <= CH3;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifndef FOUR_TO_ONE_FIXED_PRI_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.in_ready  = accept ? gnt_onehot : 4'b0000;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_four_to_one_rr_mux.sv
// tb/tb_four_to_one_rr_mux.sv - scoreboard bench for four_to_one_rr_mux
`timescale 1ns/1ps
module tb_four_to_one_rr_mux;

    localparam int DW = 8;
    localparam logic [DW-1:0] INACT = 8'h00;

    logic clk;
    logic rst_n;

    four_to_one_rr_mux_if #(.DATA_W(DW)) bus ();

    four_to_one_rr_mux #(.DATA_W(DW), .INACTIVE(INACT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       vis;
        logic [1:0] sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 0;

    // Reference model state: is the output slot occupied, who was granted last.
    bit m_full = 0;
    int m_last = 3;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int last);
`ifdef FOUR_TO_ONE_FIXED_PRI_EN
        for (int c = 0; c < 4; c++) if (v[c]) return c;
`else
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    // One clock of stimulus: drive at the falling edge, check in_ready,
    // and advance the model for the rising edge that ends this cycle.
    task automatic step(input logic [3:0] v, input logic [4*DW-1:0] d, input logic rdy);
        int g;
        bit acc;
        logic [3:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        cyc++;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        g   = pick(v, m_last);
        acc = (!m_full || rdy) && (g >= 0);
        exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", bus.in_ready, exp_rdy);
        if (acc) begin
            e.vis  = cyc + 1;
            e.sel  = 2'(g);
            e.data = d[g*DW +: DW];
            exp_q.push_back(e);
            m_last = g;
            m_full = 1;
        end else if (m_full && rdy) begin
            m_full = 0;
        end
    endtask

    // Monitor: compares the output register against the scoreboard front.
    initial begin
        bit vis;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && mon_en) begin
                vis = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
                chk("out_valid", bus.out_valid, vis);
                if (vis) begin
                    chk("out_sel", bus.out_sel, exp_q[0].sel);
                    chk("out_data", bus.out_data, exp_q[0].data);
                    if (bus.out_valid && bus.out_ready) void'(exp_q.pop_front());
                end else begin
                    chk("idle_data", bus.out_data, INACT);
                    chk("idle_sel", bus.out_sel, 2'b00);
                end
            end
        end
    end

    function automatic logic [4*DW-1:0] pack(input logic [7:0] d3, input logic [7:0] d2,
                                             input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, INACT);
        chk("rst_out_sel", bus.out_sel, 0);
        rst_n  = 1'b1;
        mon_en = 1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) step(4'b0000, '0, 1'b1);

        // Single requester on channel 2.
        for (int i = 0; i < 4; i++) step(4'b0100, pack(8'h11, 8'hA5 + 8'(i), 8'h22, 8'h33), 1'b1);

        // Drain with nothing pending.
        for (int i = 0; i < 2; i++) step(4'b0000, '0, 1'b1);

        // All four requesting continuously.
        for (int i = 0; i < 8; i++)
            step(4'b1111, pack(8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'h00 + 8'(i)), 1'b1);

        // Backpressure with 3C from channel 1 held.
        step(4'b0010, pack(8'h00, 8'h00, 8'h3C, 8'h00), 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, pack(8'hD3, 8'hD2, 8'hD1, 8'hD0), 1'b0);
        step(4'b1111, pack(8'hD3, 8'hD2, 8'hD1, 8'hD0), 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1);

        // Asynchronous reset while holding 77.
        step(4'b0001, pack(8'h00, 8'h00, 8'h00, 8'h77), 1'b1);
        @(negedge clk);
        cyc++;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        #1;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_out_data", bus.out_data, 8'h77);
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_out_data", bus.out_data, INACT);
        chk("async_rst_out_sel", bus.out_sel, 0);
        chk("async_rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        m_full = 0;
        m_last = 3;
        @(negedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b1111, pack(8'h43, 8'h42, 8'h41, 8'h40), 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(4'($urandom), 32'($urandom), ($urandom_range(0, 9) < 7));

        for (int i = 0; i < 3; i++) step(4'b0000, '0, 1'b1);
        @(negedge clk);
        #4;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
